// File: rtl/rom_read_sequencer_pkg.sv
// Shared constants for the ROM read sequencer and the lookup ROM it feeds.
// Keeping the geometry here means the ROM and the sequencer always agree.
package rom_read_sequencer_pkg;

  localparam int ADDR_W = 1;
  localparam int DATA_W = 4;
  localparam int DEPTH  = 2;

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Requests larger than the ROM are clamped to the full ROM.
  function automatic logic [ADDR_W:0] sat_count(input logic [ADDR_W:0] c);
    return (c > DEPTH_W) ? DEPTH_W : c;
  endfunction

endpackage

// File: rtl/rom_read_sequencer_if.sv
// Control, ROM-side and stream-side signals of the ROM read sequencer.
// The master modport is the sequencer; the slave modport is its surroundings.
interface rom_read_sequencer_if
  import rom_read_sequencer_pkg::*;
();

  logic              start;
  logic [ADDR_W:0]   count;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_q;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    input  start, count, rom_q, out_ready,
    output busy, done, rom_addr, out_data, out_valid
  );

  modport slave (
    output start, count, rom_q, out_ready,
    input  busy, done, rom_addr, out_data, out_valid
  );

endinterface

// File: rtl/rom_read_sequencer_stream_buf2.sv
// Two-entry FIFO that soaks up the ROM read latency under backpressure.
// Simultaneous push and pop keep the occupancy and preserve order.
module stream_buf2 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);

  logic       wr_ptr_reg;
  logic       rd_ptr_reg;
  logic [1:0] count_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      logic [WIDTH-1:0] entry_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          entry_reg <= '0;
        end else if (push && (wr_ptr_reg == 1'(gi))) begin
          entry_reg <= push_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head  = rd_ptr_reg ? g_entry[1].entry_reg : g_entry[0].entry_reg;
  assign count = count_reg;

endmodule

// File: rtl/rom_read_sequencer.sv
// Walks ROM addresses 0..count-1 and streams the returned words downstream.
// Issue credits (buffered + in flight) never exceed the two buffer slots.
module rom_read_sequencer
  import rom_read_sequencer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  rom_read_sequencer_if.master bus
);

  localparam logic [ADDR_W:0] ONE_W = (ADDR_W + 1)'(1);

  state_t            state_reg;
  logic [ADDR_W:0]   remaining_reg;
  logic [ADDR_W:0]   issues_left_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              pending_reg;
  logic              busy_reg;
  logic              done_reg;

  logic [1:0]        buf_count;
  logic [DATA_W-1:0] buf_head;
  logic              out_valid;
  logic              issue;
  logic              pop;

  assign out_valid = (buf_count != 2'd0);
  assign pop       = out_valid && bus.out_ready;

  // The ROM samples addr_reg on every edge, so an issue is simply a cycle in
  // which the address is held and a free slot is reserved for its word.
  assign issue = (state_reg == RUN) && (issues_left_reg != '0) &&
                 ((3'(buf_count) + 3'(pending_reg)) < 3'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      remaining_reg   <= '0;
      issues_left_reg <= '0;
      addr_reg        <= '0;
      pending_reg     <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      done_reg    <= 1'b0;
      pending_reg <= issue;
      if (pop) remaining_reg <= remaining_reg - ONE_W;

      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            if (bus.count == '0) begin
              done_reg <= 1'b1;
            end else begin
              remaining_reg   <= sat_count(bus.count);
              issues_left_reg <= sat_count(bus.count);
              addr_reg        <= '0;
              busy_reg        <= 1'b1;
              state_reg       <= RUN;
            end
          end
        end
        RUN: begin
          if (issue) begin
            issues_left_reg <= issues_left_reg - ONE_W;
            addr_reg        <= addr_reg + ADDR_W'(1);
            if (issues_left_reg == ONE_W) state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          // All words are issued; finish on the handshake of the last one.
          if (pop && (remaining_reg == ONE_W)) begin
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  stream_buf2 #(
    .WIDTH (DATA_W)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (pending_reg),
    .push_data (bus.rom_q),
    .pop       (pop),
    .head      (buf_head),
    .count     (buf_count)
  );

  assign bus.rom_addr  = addr_reg;
  assign bus.out_data  = buf_head;
  assign bus.out_valid = out_valid;
  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;

endmodule

// File: tb/tb_rom_read_sequencer.sv
// Directed bench for rom_read_sequencer with a 2x4 registered-read ROM model
// and an expected-word queue checked on every downstream handshake.
module tb_rom_read_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] rom_mem [2];
  logic [3:0] exp_q [$];
  int pass_cnt  = 0;
  int total_cnt = 0;
  int hs_cnt    = 0;
  int done_cnt  = 0;
  int hs0;
  int dn0;

  rom_read_sequencer_if bus_if ();

  rom_read_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) bus_if.rom_q <= rom_mem[bus_if.rom_addr];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Scoreboard side: every accepted word must match the head of the queue.
  always @(negedge clk) begin
    logic [3:0] w;
    if (bus_if.done) done_cnt++;
    if (bus_if.out_valid && bus_if.out_ready) begin
      hs_cnt++;
      check("word_expected", 8'(exp_q.size() != 0), 8'd1);
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        check("out_data", 8'(bus_if.out_data), 8'(w));
      end
    end
  end

  task automatic start_scan(input logic [1:0] n);
    int ne;
    @(posedge clk); #1;
    bus_if.start = 1'b1;
    bus_if.count = n;
    ne = (n > 2'd2) ? 2 : int'(n);
    for (int i = 0; i < ne; i++) exp_q.push_back(rom_mem[i]);
    @(posedge clk); #1;
    bus_if.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus_if.done) seen = 1'b1;
    end
    check("done_seen", 8'(seen), 8'd1);
    check("busy_with_done", 8'(bus_if.busy), 8'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rom_mem[0] = 4'h2;
    rom_mem[1] = 4'h1;
    bus_if.start     = 1'b0;
    bus_if.count     = '0;
    bus_if.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 8'(bus_if.out_valid), 8'd0);
    check("rst_busy", 8'(bus_if.busy), 8'd0);
    check("rst_done", 8'(bus_if.done), 8'd0);
    check("rst_rom_addr", 8'(bus_if.rom_addr), 8'd0);
    check("rst_out_data", 8'(bus_if.out_data), 8'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Full-rate scan: words on consecutive cycles, done one cycle later.
    start_scan(2'd2);
    @(negedge clk);
    check("t1_busy", 8'(bus_if.busy), 8'd1);
    check("t1_valid_e0", 8'(bus_if.out_valid), 8'd0);
    @(negedge clk);
    check("t1_valid_e1", 8'(bus_if.out_valid), 8'd0);
    @(negedge clk);
    check("t1_valid_e2", 8'(bus_if.out_valid), 8'd1);
    @(negedge clk);
    check("t1_valid_e3", 8'(bus_if.out_valid), 8'd1);
    @(negedge clk);
    check("t1_done", 8'(bus_if.done), 8'd1);
    check("t1_busy_fall", 8'(bus_if.busy), 8'd0);
    check("t1_valid_end", 8'(bus_if.out_valid), 8'd0);
    @(negedge clk);
    check("t1_done_pulse", 8'(bus_if.done), 8'd0);
    check("t1_done_cnt", 8'(done_cnt), 8'd1);
    check("t1_q_empty", 8'(exp_q.size()), 8'd0);

    // Backpressure: head held, issues stop after two credits.
    bus_if.out_ready = 1'b0;
    hs0 = hs_cnt;
    start_scan(2'd2);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t2_no_done", 8'(bus_if.done), 8'd0);
      if (k >= 2) begin
        check("t2_hold_valid", 8'(bus_if.out_valid), 8'd1);
        check("t2_hold_data", 8'(bus_if.out_data), 8'h2);
        check("t2_addr_stop", 8'(bus_if.rom_addr), 8'd0);
      end
    end
    @(posedge clk); #1;
    bus_if.out_ready = 1'b1;
    wait_done(20);
    check("t2_handshakes", 8'(hs_cnt - hs0), 8'd2);
    check("t2_q_empty", 8'(exp_q.size()), 8'd0);

    // Zero-length scan.
    start_scan(2'd0);
    @(negedge clk);
    check("t3_done", 8'(bus_if.done), 8'd1);
    check("t3_busy", 8'(bus_if.busy), 8'd0);
    check("t3_addr", 8'(bus_if.rom_addr), 8'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t3_no_valid", 8'(bus_if.out_valid), 8'd0);
      check("t3_done_once", 8'(bus_if.done), 8'd0);
      check("t3_addr_hold", 8'(bus_if.rom_addr), 8'd0);
    end

    // Oversized count saturates to the ROM depth.
    hs0 = hs_cnt;
    start_scan(2'd3);
    wait_done(20);
    repeat (3) @(negedge clk);
    check("t4_handshakes", 8'(hs_cnt - hs0), 8'd2);
    check("t4_q_empty", 8'(exp_q.size()), 8'd0);

    // A second start while running is ignored.
    hs0 = hs_cnt;
    dn0 = done_cnt;
    start_scan(2'd2);
    bus_if.start = 1'b1;
    bus_if.count = 2'd1;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    wait_done(20);
    repeat (4) @(negedge clk);
    check("t5_handshakes", 8'(hs_cnt - hs0), 8'd2);
    check("t5_done_cnt", 8'(done_cnt - dn0), 8'd1);
    check("t5_idle", 8'(bus_if.busy), 8'd0);
    check("t5_q_empty", 8'(exp_q.size()), 8'd0);

    // Asynchronous reset in DRAIN with one word buffered.
    bus_if.out_ready = 1'b0;
    start_scan(2'd1);
    repeat (3) @(negedge clk);
    check("t6_buffered", 8'(bus_if.out_valid), 8'd1);
    check("t6_busy_pre", 8'(bus_if.busy), 8'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 8'(bus_if.out_valid), 8'd0);
    check("t6_rst_busy", 8'(bus_if.busy), 8'd0);
    check("t6_rst_done", 8'(bus_if.done), 8'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus_if.out_ready = 1'b1;
    hs0 = hs_cnt;
    start_scan(2'd2);
    @(negedge clk);
    check("t6_addr0", 8'(bus_if.rom_addr), 8'd0);
    check("t6_busy", 8'(bus_if.busy), 8'd1);
    wait_done(20);
    check("t6_handshakes", 8'(hs_cnt - hs0), 8'd2);
    check("t6_q_empty", 8'(exp_q.size()), 8'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
